// File: rtl/alu_share_pkg.sv
// Shared constants and types for the shared-ALU controller.
// Optional flag outputs are enabled by defining ALU_SHARE_FLAGS_EN.
package alu_share_pkg;
   localparam int NREQ_DEF = 4;
   localparam int W_DEF    = 8;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;
endpackage

// File: rtl/alu_core.sv
// Combinational W-bit add/sub/and/or datapath.
// Carry/borrow and zero outputs exist only when ALU_SHARE_FLAGS_EN is defined.
module alu_core import alu_share_pkg::*; #(
   parameter int W = W_DEF
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [1:0]   op,
`ifdef ALU_SHARE_FLAGS_EN
   output logic         carry,
   output logic         zero,
`endif
   output logic [W-1:0] y
);

   always_comb begin
      y = '0;
      unique case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         default: y = '0;
      endcase
   end

`ifdef ALU_SHARE_FLAGS_EN
   logic [W:0] sum_x;
   logic [W:0] diff_x;

   assign sum_x  = {1'b0, a} + {1'b0, b};
   // top bit of the widened difference is the borrow (a < b unsigned)
   assign diff_x = {1'b0, a} - {1'b0, b};
   assign zero   = (y == '0);

   always_comb begin
      carry = 1'b0;
      unique case (op)
         OP_ADD:  carry = sum_x[W];
         OP_SUB:  carry = diff_x[W];
         default: carry = 1'b0;
      endcase
   end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter sharing one alu_core among NREQ requesters.
// Defining ALU_SHARE_FLAGS_EN adds the rsp_zero / rsp_carry outputs.
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_IDLE | grant offered to one valid requester (round-robin)
// ST_EXEC | registered operands evaluated, response captured
// ST_HOLD | rsp_valid held until rsp_ready is sampled high
module alu_share_ctrl import alu_share_pkg::*; #(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*W-1:0]          req_a,
   input  logic [NREQ*W-1:0]          req_b,
   input  logic [NREQ*2-1:0]          req_op,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [W-1:0]               rsp_y,
   output logic [$clog2(NREQ)-1:0]    rsp_id,
`ifdef ALU_SHARE_FLAGS_EN
   output logic                       rsp_zero,
   output logic                       rsp_carry,
`endif
   output logic                       busy
);

   localparam int IW = $clog2(NREQ);

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_any;
   logic [NREQ-1:0] gnt;
   logic [W-1:0]    a_q, b_q, alu_y;
   logic [1:0]      op_q;
   logic [IW-1:0]   id_q;
`ifdef ALU_SHARE_FLAGS_EN
   logic            alu_carry, alu_zero;
`endif

   // first valid requester at or after ptr_q, wrapping; blocked during reset
   always_comb begin : p_grant
      int j;
      j       = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      if (state_q == ST_IDLE && !rst) begin
         for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_q) + k) % NREQ;
            if (!gnt_any && req_valid[j]) begin
               gnt_any = 1'b1;
               gnt_idx = IW'(j);
               gnt[j]  = 1'b1;
            end
         end
      end
   end

   assign req_ready = gnt;
   assign busy      = (state_q != ST_IDLE);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (gnt_any) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_HOLD;
         ST_HOLD: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         id_q      <= '0;
         rsp_valid <= 1'b0;
         rsp_y     <= '0;
         rsp_id    <= '0;
`ifdef ALU_SHARE_FLAGS_EN
         rsp_zero  <= 1'b0;
         rsp_carry <= 1'b0;
`endif
      end else begin
         if (gnt_any) begin
            a_q   <= req_a[gnt_idx*W +: W];
            b_q   <= req_b[gnt_idx*W +: W];
            op_q  <= req_op[gnt_idx*2 +: 2];
            id_q  <= gnt_idx;
            ptr_q <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
         end
         if (state_q == ST_EXEC) begin
            rsp_valid <= 1'b1;
            rsp_y     <= alu_y;
            rsp_id    <= id_q;
`ifdef ALU_SHARE_FLAGS_EN
            rsp_zero  <= alu_zero;
            rsp_carry <= alu_carry;
`endif
         end else if (state_q == ST_HOLD && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

   alu_core #(.W(W)) u_core (
      .a     (a_q),
      .b     (b_q),
      .op    (op_q),
`ifdef ALU_SHARE_FLAGS_EN
      .carry (alu_carry),
      .zero  (alu_zero),
`endif
      .y     (alu_y)
   );

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios plus random traffic
// against a transaction-level reference model. Flags checked when ALU_SHARE_FLAGS_EN is defined.
module tb_alu_share_ctrl;
   import alu_share_pkg::*;

   localparam int NREQ = 4;
   localparam int W    = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a, req_b;
   logic [NREQ*2-1:0] req_op;
   logic              rsp_valid, rsp_ready;
   logic [W-1:0]      rsp_y;
   logic [1:0]        rsp_id;
   logic              busy;
`ifdef ALU_SHARE_FLAGS_EN
   logic              rsp_zero, rsp_carry;
`endif

   alu_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_id    (rsp_id),
`ifdef ALU_SHARE_FLAGS_EN
      .rsp_zero  (rsp_zero),
      .rsp_carry (rsp_carry),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: one outstanding transaction, age counts cycles since grant
   int m_ptr = 0;
   bit m_inflight = 0;
   int m_age = 0;
   int m_y, m_id, m_c;
   int cyc = 0;

   int obs_valid, obs_y, obs_id, obs_rr, obs_busy, obs_c, obs_z;
   int gnt_log_id[$];
   int gnt_log_cyc[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int ref_alu(input int a, input int b, input int op, output int carry);
      int r;
      int m;
      m = 1 << W;
      carry = 0;
      case (op)
         0: begin r = a + b; carry = (r >= m) ? 1 : 0; end
         1: begin r = a - b; carry = (a < b) ? 1 : 0; end
         2: r = a & b;
         default: r = a | b;
      endcase
      if (r < 0) r = r + m;
      return r % m;
   endfunction

   task automatic step();
      int exp_gnt;
      logic [NREQ-1:0] exp_rr;
      bit exp_valid;
      @(negedge clk);
      exp_gnt = -1;
      exp_rr  = '0;
      if (!rst && !m_inflight) begin
         for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (exp_gnt < 0 && req_valid[j]) exp_gnt = j;
         end
      end
      if (exp_gnt >= 0) exp_rr[exp_gnt] = 1'b1;
      exp_valid = m_inflight && (m_age >= 2);

      check_val("req_ready", 32'(req_ready), 32'(exp_rr));
      check_val("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      check_val("busy", 32'(busy), 32'(m_inflight));
      if (exp_valid) begin
         check_val("rsp_y", 32'(rsp_y), 32'(m_y));
         check_val("rsp_id", 32'(rsp_id), 32'(m_id));
`ifdef ALU_SHARE_FLAGS_EN
         check_val("rsp_carry", 32'(rsp_carry), 32'(m_c));
         check_val("rsp_zero", 32'(rsp_zero), 32'(m_y == 0));
`endif
      end

      obs_valid = int'(rsp_valid);
      obs_y     = int'(rsp_y);
      obs_id    = int'(rsp_id);
      obs_rr    = int'(req_ready);
      obs_busy  = int'(busy);
`ifdef ALU_SHARE_FLAGS_EN
      obs_c     = int'(rsp_carry);
      obs_z     = int'(rsp_zero);
`else
      obs_c     = 0;
      obs_z     = 0;
`endif
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            gnt_log_id.push_back(i);
            gnt_log_cyc.push_back(cyc);
         end
      end

      if (rst) begin
         m_inflight = 0;
         m_ptr      = 0;
      end else if (m_inflight) begin
         if (m_age >= 2 && rsp_ready) m_inflight = 0;
         else if (m_age < 2) m_age++;
      end else if (exp_gnt >= 0) begin
         m_inflight = 1;
         m_age      = 1;
         m_id       = exp_gnt;
         m_y        = ref_alu(int'(req_a[exp_gnt*W +: W]), int'(req_b[exp_gnt*W +: W]),
                              int'(req_op[exp_gnt*2 +: 2]), m_c);
         m_ptr      = (exp_gnt + 1) % NREQ;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic rand_operands();
      req_a  = $urandom;
      req_b  = $urandom;
      req_op = 8'($urandom);
   endtask

   task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic [7:0] exp_y,
                          input int exp_c, input int exp_z);
      rand_operands();
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
      req_op[id*2 +: 2] = op;
      req_valid = NREQ'(1 << id);
      rsp_ready = 1'b0;
      step();
      check_val("one_grant", 32'(obs_rr), 32'(1 << id));
      req_valid = '0;
      rand_operands();
      step();
      check_val("one_lat_n1", 32'(obs_valid), 32'd0);
      rsp_ready = 1'b1;
      step();
      check_val("one_lat_n2", 32'(obs_valid), 32'd1);
      check_val("one_y", 32'(obs_y), 32'(exp_y));
      check_val("one_id", 32'(obs_id), 32'(id));
`ifdef ALU_SHARE_FLAGS_EN
      check_val("one_carry", 32'(obs_c), 32'(exp_c));
      check_val("one_zero", 32'(obs_z), 32'(exp_z));
`endif
      rsp_ready = 1'b0;
      step();
      check_val("one_idle", 32'(obs_busy), 32'd0);
   endtask

   initial begin
      int nlog;
      int saved_y, saved_id;

      rst = 1'b1;
      req_valid = '1;
      req_a = '0;
      req_b = '0;
      req_op = '0;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      step();
      check_val("rst_y", 32'(rsp_y), 32'd0);
      check_val("rst_id", 32'(rsp_id), 32'd0);
      check_val("rst_valid", 32'(rsp_valid), 32'd0);
      check_val("rst_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      req_valid = '0;

      run_one(0, 8'h7F, 8'h01, OP_ADD, 8'h80, 0, 0);
      run_one(1, 8'h00, 8'h01, OP_SUB, 8'hFF, 1, 0);
      run_one(2, 8'hFF, 8'h01, OP_ADD, 8'h00, 1, 1);
      run_one(3, 8'hF0, 8'h3C, OP_AND, 8'h30, 0, 0);
      run_one(0, 8'hF0, 8'h3C, OP_OR,  8'hFC, 0, 0);

      // backpressure: response held with every requester waiting
      rand_operands();
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      step();
      req_valid = '1;
      step();
      nlog = gnt_log_id.size();
      step();
      saved_y  = obs_y;
      saved_id = obs_id;
      for (int i = 0; i < 5; i++) begin
         rand_operands();
         step();
         check_val("bp_ready", 32'(obs_rr), 32'd0);
      end
      check_val("bp_y_stable", 32'(obs_y), 32'(saved_y));
      check_val("bp_id_stable", 32'(obs_id), 32'(saved_id));
      check_val("bp_nogrant", 32'(gnt_log_id.size()), 32'(nlog));
      rsp_ready = 1'b1;
      step();
      req_valid = '0;
      rsp_ready = 1'b0;
      step();
      check_val("bp_idle", 32'(obs_busy), 32'd0);

      // contention straight after reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b1;
      nlog = gnt_log_id.size();
      for (int i = 0; i < 14; i++) begin
         rand_operands();
         step();
      end
      check_val("cont_count_ok", 32'(gnt_log_id.size() >= nlog + 5), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (gnt_log_id.size() > nlog + i) begin
            check_val("cont_id", 32'(gnt_log_id[nlog+i]), 32'(i % NREQ));
            if (i > 0)
               check_val("cont_interval", 32'(gnt_log_cyc[nlog+i] - gnt_log_cyc[nlog+i-1]), 32'd3);
         end
      end

      // reset in EXEC discards the operation and rewinds the pointer
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_val("rst_mid_novalid", 32'(obs_valid), 32'd0);
      end
      req_valid = '1;
      nlog = gnt_log_id.size();
      step();
      check_val("rst_mid_count", 32'(gnt_log_id.size()), 32'(nlog + 1));
      if (gnt_log_id.size() > nlog)
         check_val("rst_mid_winner", 32'(gnt_log_id[nlog]), 32'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         req_valid = NREQ'($urandom);
         rand_operands();
         rsp_ready = ($urandom % 4) != 0;
         rst = ($urandom % 64) == 0;
         step();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; SHALL be 2..8.
REQ-002 Parameter W, default 8, operand/result width in bits.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port req_valid  input  NREQ  per-requester request valid.
REQ-006 Port req_ready  output  NREQ  per-requester accept, at most one bit high.
REQ-007 Port req_a, req_b  input  NREQ*W  operands; requester i occupies bits [i*W +: W].
REQ-008 Port req_op  input  NREQ*2  opcode per requester, [i*2 +: 2]; 00 add, 01 sub, 10 AND, 11 OR.
REQ-009 Port rsp_valid  output  1  result available.
REQ-010 Port rsp_ready  input  1  consumer accepts result.
REQ-011 Port rsp_y  output  W  result.
REQ-012 Port rsp_id  output  clog2(NREQ)  index of the requester that owns rsp_y.
REQ-013 Port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and HOLD.
REQ-015 In IDLE with any req_valid set, exactly one req_ready bit SHALL be driven combinationally: the round-robin grant.
- A transfer occurs when req_valid[i] and req_ready[i] are both high.
- On a transfer, operands, op and index SHALL be registered and the state SHALL move to EXEC.
REQ-016 req_ready SHALL be all-zero in EXEC and HOLD, and in IDLE when no req_valid bit is set.
REQ-017 Round-robin: the search starts at pointer p. After a grant to i, p SHALL become (i+1) mod NREQ. With no grant, p SHALL be unchanged.
REQ-018 In EXEC, the registered operands SHALL be evaluated. rsp_y and rsp_id SHALL be registered, rsp_valid SHALL be set and the state SHALL move to HOLD.
REQ-019 Latency: for a transfer in cycle N, rsp_valid SHALL be high from cycle N+2.
REQ-020 In HOLD, rsp_valid, rsp_y and rsp_id SHALL be held stable until rsp_ready is sampled high. On that edge rsp_valid SHALL clear and the state SHALL move to IDLE.
REQ-021 Minimum issue interval SHALL be 3 cycles. A request arriving while busy SHALL wait and SHALL NOT be dropped.
REQ-022 Arithmetic SHALL be modulo 2^W:
- add: A+B, carry discarded.
- sub: A-B in two's complement; 0x00-0x01 = 0xFF at W=8.
- AND and OR: bitwise.
REQ-023 req_valid deasserting while not granted is legal. req_valid, operands and op changing in non-transfer cycles SHALL have no effect.
REQ-024 rsp_ready high while rsp_valid is low SHALL be ignored.

Reset
REQ-025 While rst is high at a clock edge:
- state SHALL become IDLE, p SHALL become 0, and rsp_valid SHALL become 0;
- rsp_y, rsp_id and operand registers SHALL become 0;
- req_ready SHALL be 0 during the reset cycle.
REQ-026 Reset during EXEC or HOLD SHALL discard the in-flight operation; no response for it SHALL ever appear.

Configuration
REQ-027 Macro ALU_SHARE_FLAGS_EN defined SHALL add two outputs, registered with rsp_y and valid under the same rsp_valid:
- rsp_zero (1): high when rsp_y == 0.
- rsp_carry (1): carry-out for add, borrow (A<B unsigned) for sub, 0 for AND/OR.
- Both SHALL reset to 0.
REQ-028 Without ALU_SHARE_FLAGS_EN these ports SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-029 Shared package alu_share_pkg SHALL hold:
- opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR;
- the FSM state typedef;
- default NREQ and W constants.
REQ-030 Sub-module alu_core SHALL contain the combinational W-bit four-op datapath. alu_share_ctrl SHALL instantiate it once.
REQ-031 alu_core SHALL provide carry/borrow and zero outputs only under ALU_SHARE_FLAGS_EN.

Verification
REQ-032 Bench SHALL cover the following scenarios:
- Single request: req_valid=0001, A=0x7F, B=0x01, op=00 -> ready[0] cycle N; rsp_valid at N+2; rsp_y=0x80, rsp_id=0; with flags enabled, carry=0 and zero=0.
- Contention: all four requesting continuously after reset, rsp_ready=1 -> grants in order 0,1,2,3,0, one grant every 3 cycles.
- Wrap and flags: A=0x00, B=0x01, op=01 -> rsp_y=0xFF, carry=1; A=0xFF, B=0x01, op=00 -> rsp_y=0x00, carry=1, zero=1.
- Backpressure: rsp_ready=0 for 5 cycles in HOLD -> rsp_y and rsp_id stable, req_ready=0, no new grant; rsp_ready=1 -> IDLE next cycle.
- Reset mid-op: assert rst in EXEC -> rsp_valid stays 0, p=0, and requester 0 wins the next contention.
- Logic ops: A=0xF0, B=0x3C -> AND gives 0x30, OR gives 0xFC.
